// File: rtl/rom_pkg.sv
// rom_pkg: constants shared by the ROM, the arbiter and the bench.
//   ROM_WIDTH      - data word width
//   ROM_DEPTH      - number of ROM words
//   ROM_ADDR_WIDTH - address width derived from the depth
//   rsp_state_e    - response tracker states (IDLE, ISSUED)
package rom_pkg;

  localparam int ROM_WIDTH      = 16;
  localparam int ROM_DEPTH      = 64;
  localparam int ROM_ADDR_WIDTH = $clog2(ROM_DEPTH);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ISSUED = 1'b1
  } rsp_state_e;

endpackage : rom_pkg

// File: rtl/rom.sv
// rom: single-port read-only memory, one cycle read latency.
// Contents are mem[i] = i, generated from the address rather than stored.
//   clk_i   - clock, rising edge
//   rst_i   - active-high synchronous reset of the output register
//   en_i    - read enable
//   addr_i  - read address
//   rdata_o - registered read data
module rom
  import rom_pkg::*;
#(
  parameter int ADDR_WIDTH = ROM_ADDR_WIDTH,
  parameter int WIDTH      = ROM_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic [WIDTH-1:0]      rdata_o
);

  logic [WIDTH-1:0] rdata_q;

  // Output register: the word value equals its zero-extended address.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (en_i) begin
      rdata_q <= WIDTH'(addr_i);
    end else begin
      rdata_q <= rdata_q;
    end
  end

  assign rdata_o = rdata_q;

endmodule : rom

// File: rtl/rom_arbiter_rr_pick.sv
// rr_pick: combinational round-robin search.
//   req_i   - request vector
//   ptr_i   - index where the search starts (wraps upward)
//   mask_i  - requests to exclude from this search
//   gnt_o   - one-hot grant, zero when nothing eligible
//   idx_o   - winner index (0 when nothing eligible)
//   valid_o - a winner exists
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  input  logic [NUM_REQ-1:0] mask_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o
);

  logic [NUM_REQ-1:0] req_eff_s;
  logic [IDX_W-1:0]   k_s;
  logic               found_s;

  assign req_eff_s = req_i & ~mask_i;

  // First eligible request at or after ptr_i, wrapping past NUM_REQ-1.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    found_s = 1'b0;
    k_s     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k_s = IDX_W'((32'(ptr_i) + 32'(i)) % 32'(NUM_REQ));
      if (!found_s && req_eff_s[k_s]) begin
        gnt_o[k_s] = 1'b1;
        idx_o      = k_s;
        found_s    = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
    valid_o = found_s;
  end

endmodule : rr_pick

// File: rtl/rom_arbiter.sv
// rom_arbiter: round-robin arbiter sharing one 1-cycle-latency ROM.
//   clk_i, rst_ni - clock and asynchronous active-low reset
//   req_i, lock_i - per-requester read request and ownership-lock request
//   addr_i        - packed per-requester addresses
//   gnt_o         - one-hot grant (combinational, same cycle as request)
//   rvalid_o      - one-hot response valid, one cycle after the grant
//   rdata_o       - shared response data
//   rom_en_o, rom_addr_o, rom_rdata_i, rom_rst_o - ROM side
module rom_arbiter
  import rom_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = ROM_ADDR_WIDTH,
  parameter int WIDTH      = ROM_WIDTH,
  parameter int MAX_LOCK   = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ-1:0]            lock_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr_i,
  output logic [NUM_REQ-1:0]            gnt_o,
  output logic [NUM_REQ-1:0]            rvalid_o,
  output logic [WIDTH-1:0]              rdata_o,
  output logic                          rom_en_o,
  output logic [ADDR_WIDTH-1:0]         rom_addr_o,
  input  logic [WIDTH-1:0]              rom_rdata_i,
  output logic                          rom_rst_o
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_LOCK + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  rsp_state_e       state_q, state_d;
  logic [IDX_W-1:0] rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;

  logic [NUM_REQ-1:0] pick_gnt_s;
  logic [IDX_W-1:0]   pick_idx_s;
  logic               pick_valid_s;
  logic [NUM_REQ-1:0] mask_s;
  logic               consec_s;
  logic [CNT_W-1:0]   cnt_eff_s;
  logic               lock_apply_s;

  // While in reset every request is masked so nothing is granted.
  assign mask_s = {NUM_REQ{~rst_ni}};

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .mask_i  (mask_s),
    .gnt_o   (pick_gnt_s),
    .idx_o   (pick_idx_s),
    .valid_o (pick_valid_s)
  );

  // A grant is consecutive when the previous cycle granted the same index;
  // otherwise the run count starts from zero for this grant.
  assign consec_s     = (state_q == ISSUED) && (rsp_id_q == pick_idx_s);
  assign cnt_eff_s    = consec_s ? lock_cnt_q : '0;
  assign lock_apply_s = lock_i[pick_idx_s] && (32'(cnt_eff_s) < 32'(MAX_LOCK - 1));

  assign gnt_o      = pick_gnt_s;
  assign rom_en_o   = pick_valid_s;
  assign rom_addr_o = pick_valid_s ? addr_i[pick_idx_s*ADDR_WIDTH +: ADDR_WIDTH] : '0;
  assign rom_rst_o  = ~rst_ni;
  assign rdata_o    = (state_q == ISSUED) ? rom_rdata_i : rdata_q;

  // Next-state: pointer, lock run count, response tracker, held data.
  always_comb begin
    ptr_d      = ptr_q;
    lock_cnt_d = '0;
    state_d    = IDLE;
    rsp_id_d   = rsp_id_q;
    rdata_d    = rdata_q;
    if (pick_valid_s) begin
      state_d  = ISSUED;
      rsp_id_d = pick_idx_s;
      if (lock_apply_s) begin
        ptr_d = pick_idx_s;
      end else if (pick_idx_s == IDX_LAST) begin
        ptr_d = '0;
      end else begin
        ptr_d = pick_idx_s + IDX_ONE;
      end
      // At the limit the count wraps so a sole locked owner starts a new run.
      if (32'(cnt_eff_s) >= 32'(MAX_LOCK - 1)) begin
        lock_cnt_d = '0;
      end else begin
        lock_cnt_d = cnt_eff_s + CNT_ONE;
      end
    end else begin
      ptr_d = ptr_q;
    end
    case (state_q)
      IDLE:    rdata_d = rdata_q;
      ISSUED:  rdata_d = rom_rdata_i;
      default: rdata_d = rdata_q;
    endcase
  end

  // Response valid decode from the registered tracker state.
  always_comb begin
    rvalid_o = '0;
    if (state_q == ISSUED) begin
      rvalid_o[rsp_id_q] = 1'b1;
    end else begin
      rvalid_o = '0;
    end
  end

  // State registers; reset drops any outstanding response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q      <= '0;
      lock_cnt_q <= '0;
      state_q    <= IDLE;
      rsp_id_q   <= '0;
      rdata_q    <= '0;
    end else begin
      ptr_q      <= ptr_d;
      lock_cnt_q <= lock_cnt_d;
      state_q    <= state_d;
      rsp_id_q   <= rsp_id_d;
      rdata_q    <= rdata_d;
    end
  end

endmodule : rom_arbiter

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: directed stimulus with a response scoreboard for rom_arbiter.
module tb_rom_arbiter;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic [3:0]  req_i;
  logic [3:0]  lock_i;
  logic [23:0] addr_i;
  logic [3:0]  gnt_o;
  logic [3:0]  rvalid_o;
  logic [15:0] rdata_o;
  logic        rom_en;
  logic [5:0]  rom_addr;
  logic [15:0] rom_rdata;
  logic        rom_rst;

  typedef struct {
    logic [3:0]  id;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  rom_arbiter #(
    .NUM_REQ(4), .ADDR_WIDTH(6), .WIDTH(16), .MAX_LOCK(4)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .lock_i(lock_i), .addr_i(addr_i),
    .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .rom_en_o(rom_en),
    .rom_addr_o(rom_addr), .rom_rdata_i(rom_rdata), .rom_rst_o(rom_rst)
  );

  rom #(.ADDR_WIDTH(6), .WIDTH(16)) u_rom (
    .clk_i(clk), .rst_i(rom_rst), .en_i(rom_en), .addr_i(rom_addr), .rdata_o(rom_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [23:0] pk(input logic [5:0] a0, input logic [5:0] a1,
                                     input logic [5:0] a2, input logic [5:0] a3);
    return {a3, a2, a1, a0};
  endfunction

  // One cycle of stimulus; checks the same-cycle grant and queues the response.
  task automatic drive(input string name, input logic [3:0] req, input logic [3:0] lock,
                       input logic [23:0] addrs, input logic [3:0] exp_gnt,
                       input logic [5:0] exp_addr);
    exp_t e;
    @(posedge clk);
    #1;
    req_i  = req;
    lock_i = lock;
    addr_i = addrs;
    @(negedge clk);
    check({name, "_gnt"}, 32'(gnt_o), 32'(exp_gnt));
    check({name, "_en"}, 32'(rom_en), 32'(exp_gnt != 4'b0000));
    check({name, "_addr"}, 32'(rom_addr), 32'(exp_addr));
    if (exp_gnt != 4'b0000) begin
      e.id   = exp_gnt;
      e.data = 16'(exp_addr);
      e.cyc  = cyc + 1;
      exp_q.push_back(e);
    end
  endtask

  // Response monitor: every rvalid must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rvalid_o != 4'b0000) begin
      if (exp_q.size() == 0) begin
        check("rvalid_spurious", 32'(rvalid_o), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_id", 32'(rvalid_o), 32'(mon_e.id));
        check("rsp_data", 32'(rdata_o), 32'(mon_e.data));
        check("rsp_cycle", 32'(cyc), 32'(mon_e.cyc));
      end
    end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
      mon_e = exp_q.pop_front();
      check("rsp_missing", 32'(rvalid_o), 32'(mon_e.id));
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_ni = 1'b0;
    req_i  = 4'b1111;
    lock_i = 4'b0000;
    addr_i = pk(6'd1, 6'd2, 6'd3, 6'd4);
    #3;
    check("rst_gnt", 32'(gnt_o), 32'd0);
    check("rst_en", 32'(rom_en), 32'd0);
    check("rst_rvalid", 32'(rvalid_o), 32'd0);
    check("rst_rdata", 32'(rdata_o), 32'd0);
    check("rst_rom_rst", 32'(rom_rst), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_gnt_held", 32'(gnt_o), 32'd0);
    req_i  = 4'b0000;
    rst_ni = 1'b1;
    #1;
    check("rel_rom_rst", 32'(rom_rst), 32'd0);

    // Round robin from index 0 with all four requesting.
    drive("rr0", 4'b1111, 4'b0000, pk(6'd10, 6'd11, 6'd12, 6'd13), 4'b0001, 6'd10);
    drive("rr1", 4'b1111, 4'b0000, pk(6'd10, 6'd11, 6'd12, 6'd13), 4'b0010, 6'd11);
    drive("rr2", 4'b1111, 4'b0000, pk(6'd10, 6'd11, 6'd12, 6'd13), 4'b0100, 6'd12);
    drive("rr3", 4'b1111, 4'b0000, pk(6'd10, 6'd11, 6'd12, 6'd13), 4'b1000, 6'd13);
    drive("rr4", 4'b1111, 4'b0000, pk(6'd30, 6'd31, 6'd32, 6'd33), 4'b0001, 6'd30);
    drive("rr5", 4'b1111, 4'b0000, pk(6'd30, 6'd31, 6'd32, 6'd33), 4'b0010, 6'd31);
    drive("idle0", 4'b0000, 4'b0000, pk(6'd30, 6'd31, 6'd32, 6'd33), 4'b0000, 6'd0);
    drive("idle1", 4'b0000, 4'b0000, pk(6'd30, 6'd31, 6'd32, 6'd33), 4'b0000, 6'd0);
    check("hold_rdata", 32'(rdata_o), 32'd31);
    check("hold_rvalid", 32'(rvalid_o), 32'd0);

    // Single requester 2, address 17.
    drive("single", 4'b0100, 4'b0000, pk(6'd0, 6'd0, 6'd17, 6'd0), 4'b0100, 6'd17);
    drive("idle2", 4'b0000, 4'b0000, pk(6'd0, 6'd0, 6'd0, 6'd0), 4'b0000, 6'd0);

    // Move pointer to 1, then lock limit: four grants to 1, then 0.
    drive("pre_lk", 4'b0001, 4'b0000, pk(6'd5, 6'd40, 6'd0, 6'd0), 4'b0001, 6'd5);
    for (int i = 0; i < 4; i++) begin
      drive("lock_lim", 4'b0011, 4'b0010, pk(6'd5, 6'd40, 6'd0, 6'd0), 4'b0010, 6'd40);
    end
    drive("lock_rel", 4'b0011, 4'b0010, pk(6'd5, 6'd40, 6'd0, 6'd0), 4'b0001, 6'd5);
    drive("idle3", 4'b0000, 4'b0000, pk(6'd0, 6'd0, 6'd0, 6'd0), 4'b0000, 6'd0);

    // Lock with a sole requester: granted every cycle, no bubble at the limit.
    for (int i = 0; i < 6; i++) begin
      drive("lock_alone", 4'b0010, 4'b0010, pk(6'd0, 6'(20 + i), 6'd0, 6'd0), 4'b0010,
            6'(20 + i));
    end
    drive("idle4", 4'b0000, 4'b0000, pk(6'd0, 6'd0, 6'd0, 6'd0), 4'b0000, 6'd0);

    // Grant, then reset before the response edge: the response is dropped.
    drive("pre_rst", 4'b1111, 4'b0000, pk(6'd50, 6'd51, 6'd52, 6'd53), 4'b0010, 6'd51);
    #2;
    rst_ni = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_gnt", 32'(gnt_o), 32'd0);
    check("mid_rst_en", 32'(rom_en), 32'd0);
    check("mid_rst_rvalid", 32'(rvalid_o), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_rvalid2", 32'(rvalid_o), 32'd0);
    check("mid_rst_rdata", 32'(rdata_o), 32'd0);
    #1;
    req_i  = 4'b0000;
    rst_ni = 1'b1;

    // After reset: first grant to the lowest requesting index.
    drive("post_rst", 4'b1000, 4'b0000, pk(6'd0, 6'd0, 6'd0, 6'd63), 4'b1000, 6'd63);
    drive("idle5", 4'b0000, 4'b0000, pk(6'd0, 6'd0, 6'd0, 6'd0), 4'b0000, 6'd0);
    drive("post_rst2", 4'b1100, 4'b0000, pk(6'd0, 6'd0, 6'd44, 6'd63), 4'b0100, 6'd44);
    drive("idle6", 4'b0000, 4'b0000, pk(6'd0, 6'd0, 6'd0, 6'd0), 4'b0000, 6'd0);
    drive("idle7", 4'b0000, 4'b0000, pk(6'd0, 6'd0, 6'd0, 6'd0), 4'b0000, 6'd0);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_rom_arbiter

// File: doc/rom_arbiter.md
# rom_arbiter

Round-robin arbiter sharing one single-port, 1-cycle-latency ROM (`rom`) between `NUM_REQ` requesters. It grants at most one read per cycle, drives the ROM enable and address, and routes the returned word back to the requester that issued the read. An optional lock lets a requester hold the ROM for a bounded burst. It sits between the requesters and the ROM instance.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8).
- `ADDR_WIDTH`, 6, ROM address width.
- `WIDTH`, 16, ROM data width.
- `MAX_LOCK`, 4, maximum consecutive grants to one locked requester while others wait (≥1).
- `clk_i` input 1: single clock, rising edge.
- `rst_ni` input 1: reset, asynchronous, active-low.
- `req_i` input `NUM_REQ`: read request per requester. Held, with its address, until granted.
- `lock_i` input `NUM_REQ`: requester asks to keep ownership on its next request.
- `addr_i` input `NUM_REQ*ADDR_WIDTH`: packed addresses. Requester k uses bits `[k*ADDR_WIDTH +: ADDR_WIDTH]`.
- `gnt_o` output `NUM_REQ`: one-hot or zero. Request accepted this cycle.
- `rvalid_o` output `NUM_REQ`: one-hot or zero. `rdata_o` is valid for that requester.
- `rdata_o` output `WIDTH`: returned read data, shared by all requesters.
- `rom_en_o` output 1: ROM read enable.
- `rom_addr_o` output `ADDR_WIDTH`: ROM address.
- `rom_rdata_i` input `WIDTH`: ROM registered read data.
- `rom_rst_o` output 1: active-high synchronous reset for the ROM. Equals `!rst_ni`.

## Operation
**Arbitration**
- Arbitration is combinational each cycle over `req_i`.
- Winner is the first requesting index at or after `ptr_q`, searching upward with wrap-around.
- `gnt_o[w]` = 1.
- `rom_en_o` = 1 and `rom_addr_o` = `addr_i[w]` in the same cycle.
- No request: `gnt_o` = 0, `rom_en_o` = 0, `rom_addr_o` = 0.

**Pointer update on a grant to w**
- `ptr_q` ← (w+1) mod `NUM_REQ`, unless lock applies.

**Lock**
- Lock applies if `lock_i[w]` = 1 and `lock_cnt_q` < `MAX_LOCK`−1. Then `ptr_q` ← w.
- `lock_cnt_q` increments on each consecutive grant to the same owner. It clears on a grant to another index or on a cycle with no grant.
- At the limit, the pointer advances normally. If no other requester is pending, w is granted again and `lock_cnt_q` restarts at 0.

**Response FSM (two states)**
- IDLE → ISSUED when a grant occurs. The state records the winner in `rsp_id_q`.
- ISSUED → ISSUED on a back-to-back grant. ISSUED → IDLE with no grant.
- In ISSUED: `rvalid_o[rsp_id_q]` = 1 and `rdata_o` = `rom_rdata_i`.
- In IDLE: `rvalid_o` = 0 and `rdata_o` holds its last value.

Full throughput: one grant and one response per cycle.

## Timing
- **Reset values** (async, applied immediately): `ptr_q` = 0, `lock_cnt_q` = 0, FSM = IDLE, `rsp_id_q` = 0, `rdata_o` register = 0.
  - `gnt_o`, `rvalid_o`, and `rom_en_o` are all 0 while `rst_ni` = 0; requests are ignored.
- **Latency:** grant in cycle t → `rvalid_o` in cycle t+1, exactly one cycle.
- **Reset mid-operation:** any outstanding response is dropped. No `rvalid_o` appears after `rst_ni` rises. The first grant after reset goes to the lowest requesting index.
- **Simultaneous events:** a requester may be granted in cycle t while receiving `rvalid_o` for its cycle t−1 grant.
- **Dropped requests:** a request withdrawn before grant is never served. No partial state is kept.
- **Lock interaction:** `lock_i` is sampled only in a cycle where that requester is granted.

## Structure
- Shared package `rom_pkg`: ROM width/depth constants, `ADDR_WIDTH` derivation (`$clog2(DEPTH)`), and the FSM state enum (IDLE, ISSUED).
- One natural sub-module, `rr_pick`:
  - Combinational round-robin search.
  - Inputs: request vector, pointer, exclusion mask.
  - Outputs: one-hot grant and winner index.
- The arbiter top holds the registers and the FSM and instantiates `rr_pick`.
- The bench instantiates `rom` separately, with content mem[i] = i.

## Test plan
- **Reset and idle:** `rst_ni` low mid-cycle with `req_i` = 4'b1111 → all outputs 0 immediately. After release, the first grant is index 0.
- **Single requester:** `req_i[2]`, addr 17 → `gnt_o` = 4'b0100 in cycle t. `rvalid_o` = 4'b0100 and `rdata_o` = 17 in t+1.
- **Round-robin fairness:** all four request continuously with distinct addresses → grants 0,1,2,3,0… One `rvalid_o` per cycle, each carrying the matching address value.
- **Lock limit:** `lock_i[1]` = 1, `req_i` = 4'b0011, `MAX_LOCK` = 4 → requester 1 granted 4 consecutive times, then requester 0 granted once.
- **Lock alone:** `lock_i[1]` = 1, only requester 1 requesting → granted every cycle, no bubbles.
- **Reset mid-operation:** grant in cycle t, `rst_ni` low before t+1 edge → no `rvalid_o`. After reset, requester 3 alone, addr 63 → `rdata_o` = 63 one cycle after grant.
